// File: rtl/relu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | relu_pkg : shared types and helpers for the ReLU gradient unit         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package relu_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int SA_LENGTH_DEF  = 256;
  localparam int MASK_DEPTH_DEF = 16;

  typedef logic signed [DATA_WIDTH_DEF-1:0] act_t;
  typedef logic [SA_LENGTH_DEF-1:0]         mask_t;

  // Strictly positive only: zero maps to 0 so the derivative at 0 is 0.
  function automatic logic relu_pos(input act_t a);
    return !a[DATA_WIDTH_DEF-1] && (a != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/relu_grad_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | relu_grad_unit_if : forward, backward and output handshake bundle      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface relu_grad_unit_if
  import relu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SA_LENGTH  = SA_LENGTH_DEF
);

  logic                                 fwd_valid;
  logic                                 fwd_ready;
  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] fwd_act;
  logic                                 bwd_valid;
  logic                                 bwd_ready;
  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] bwd_grad;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] out_grad;

  modport master (
    output fwd_valid, fwd_act, bwd_valid, bwd_grad, out_ready,
    input  fwd_ready, bwd_ready, out_valid, out_grad
  );

  modport slave (
    input  fwd_valid, fwd_act, bwd_valid, bwd_grad, out_ready,
    output fwd_ready, bwd_ready, out_valid, out_grad
  );

endinterface
`default_nettype wire

// File: rtl/relu_mask_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | relu_mask_fifo : mask store, sync write, combinational head read       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module relu_mask_fifo
  import relu_pkg::*;
#(
  parameter  int WIDTH = $bits(mask_t),
  parameter  int DEPTH = MASK_DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_ff @(posedge clk) begin
    if (push_i && !clr_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/relu_grad_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | relu_grad_unit : captures ReLU masks forward, gates gradients backward |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module relu_grad_unit
  import relu_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int SA_LENGTH  = SA_LENGTH_DEF,
  parameter  int MASK_DEPTH = MASK_DEPTH_DEF,
  localparam int CNT_W      = $clog2(MASK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  relu_grad_unit_if.slave       bus,
  input  logic                  mask_clr_i,
  output logic [CNT_W-1:0]      mask_count_o
);

  logic [SA_LENGTH-1:0]                 fwd_mask;
  logic [SA_LENGTH-1:0]                 head_mask;
  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] gated_grad;
  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] out_grad_q;
  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] out_grad_d;
  logic                                 out_valid_q;
  logic                                 out_valid_d;
  logic                                 full;
  logic                                 empty;
  logic                                 fwd_ready;
  logic                                 bwd_ready;
  logic                                 push;
  logic                                 pop;

  for (genvar i = 0; i < SA_LENGTH; i++) begin : g_lane
    if (DATA_WIDTH == DATA_WIDTH_DEF) begin : g_pkg_width
      assign fwd_mask[i] = relu_pos(act_t'(bus.fwd_act[i]));
    end else begin : g_any_width
      assign fwd_mask[i] = !bus.fwd_act[i][DATA_WIDTH-1] && (bus.fwd_act[i] != '0);
    end
    assign gated_grad[i] = head_mask[i] ? bus.bwd_grad[i] : '0;
  end

  // A flush cycle refuses both sides; readies never look at the valids.
  assign fwd_ready = !mask_clr_i && !full;
  assign bwd_ready = !mask_clr_i && !empty && (!out_valid_q || bus.out_ready);
  assign push      = bus.fwd_valid && fwd_ready;
  assign pop       = bus.bwd_valid && bwd_ready;

  relu_mask_fifo #(
    .WIDTH (SA_LENGTH),
    .DEPTH (MASK_DEPTH)
  ) u_mask_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (mask_clr_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (fwd_mask),
    .rdata_o (head_mask),
    .count_o (mask_count_o),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_grad_d  = out_grad_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_grad_d  = gated_grad;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_grad_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_grad_q  <= out_grad_d;
    end
  end

  assign bus.fwd_ready = fwd_ready;
  assign bus.bwd_ready = bwd_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_grad  = out_grad_q;

endmodule
`default_nettype wire
